if_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the IF/ID pipeline register.
//  - Owns the PC and issues in-order requests to instruction memory over a req/gnt/rvalid handshake.
//  - Buffers returned words in a small fetch queue.
//  - Presents one {PC+4, instruction} pair per cycle to IF/ID.
//  - Honours hazard-unit stalls and branch/jump redirects from later stages.

---
 rtl/if_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, issues in-order requests to instruction memory, buffers the
// returned words in a DEPTH-entry queue and presents one {PC+4, IR} per cycle.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (adds the fetch_misalign output).
//
// Handshakes:
//   imem request : transfers at posedge when imem_req && imem_gnt. imem_req and
//                  imem_addr stay stable until that transfer; only a redirect
//                  may withdraw or retarget a pending request.
//   imem response: imem_rvalid/imem_rdata is a one-cycle push with no
//                  backpressure; the credit rule guarantees queue space.
//   IF/ID        : the queue head transfers at posedge when inst_valid && !stall.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] PC_out,
  output logic [31:0] IR_out,
  output logic [1:0]  dbg_state_o
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  // Counter width covers 0..4 (DEPTH is limited to 2..4).
  localparam int             CW      = 3;
  localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d;    // granted, response not yet received, not dropped
  logic [CW-1:0]   drop_q, drop_d;  // in-flight responses to discard
  logic [CW-1:0]   cnt_q, cnt_d;    // queue occupancy
  logic [31:0]     pc4_q [DEPTH];
  logic [31:0]     pc4_d [DEPTH];
  logic [31:0]     ir_q  [DEPTH];
  logic [31:0]     ir_d  [DEPTH];

  logic            gnt_acc;
  logic            pop;
  logic            resp_drop;
  logic            resp_push;
  logic [CW-1:0]   wr_idx;
  logic [31:0]     resp_pc4;
  logic [CW:0]     credits_d;

  assign dbg_state_o = state_q;
  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign inst_valid  = (cnt_q != '0);
  assign PC_out      = inst_valid ? pc4_q[0] : 32'h0;
  assign IR_out      = inst_valid ? ir_q[0]  : 32'h0;

  // Next-state: request accounting, queue shift/push, redirect flush, FSM.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    out_d     = out_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    pc4_d     = pc4_q;
    ir_d      = ir_q;

    gnt_acc   = imem_req && imem_gnt;
    pop       = inst_valid && !stall;
    resp_drop = imem_rvalid && (drop_q != '0);
    resp_push = imem_rvalid && (drop_q == '0) && (out_q != '0);
    // Responses return in order, so the oldest live request sits out_q words
    // behind pc_q; its PC+4 is pc_q - 4*(out_q-1).
    resp_pc4  = pc_q - (32'(out_q) << 2) + 32'd4;
    wr_idx    = cnt_q - CW'(pop);

    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        pc4_d[i] = pc4_q[i+1];
        ir_d[i]  = ir_q[i+1];
      end
    end
    if (resp_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          pc4_d[i] = resp_pc4;
          ir_d[i]  = imem_rdata;
        end
      end
    end

    cnt_d  = cnt_q - CW'(pop) + CW'(resp_push);
    out_d  = out_q + CW'(gnt_acc) - CW'(resp_push);
    drop_d = drop_q - CW'(resp_drop);
    if (gnt_acc) begin
      pc_d = pc_q + 32'd4;
    end

    // Redirect: everything in flight (including a grant this cycle) becomes a
    // drop; whichever response arrives this cycle retires one of them.
    if (redirect_valid) begin
      cnt_d  = '0;
      drop_d = drop_q + out_q + CW'(gnt_acc)
             - CW'(imem_rvalid && ((drop_q != '0) || (out_q != '0)));
      out_d  = '0;
      pc_d   = redirect_pc & 32'hFFFF_FFFC;
    end

    // Requests are issued only while a credit is free; drops hold credits so
    // discarded responses can never overrun the queue. IDLE always has zero
    // credits in use, so it leaves for REQ after its single cycle.
    credits_d = {1'b0, out_d} + {1'b0, cnt_d} + {1'b0, drop_d};
    state_d   = (credits_d >= DEPTH_C) ? S_HOLD : S_REQ;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc4_q[i] <= '0;
        ir_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      pc4_q   <= pc4_d;
      ir_q    <= ir_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;
  assign fetch_misalign = misalign_q;

  // One-cycle flag for a redirect target that was not word aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit with an in-order memory
// model, a scoreboard of expected fetch addresses and per-cycle checks.
module tb_if_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] PC_out;
  logic [31:0] IR_out;
  logic [1:0]  dbg_state;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .PC_out         (PC_out),
    .IR_out         (IR_out),
    .dbg_state_o    (dbg_state)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  int          n_consumed = 0;
  mreq_t       mem_q[$];       // granted requests awaiting a memory response
  logic [31:0] exp_q[$];       // fetch addresses expected at the output, in order
  logic [31:0] exp_req = RESET_PC;
  bit          prev_rst = 1'b1;
  bit          prev_redir = 1'b0;
  logic [31:0] prev_rpc = 32'h0;
  bit          prev_hold = 1'b0;
  logic [31:0] hold_pc = 32'h0;
  logic [31:0] hold_ir = 32'h0;
  bit          prev_wait = 1'b0;
  logic [31:0] wait_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- memory driver ----------------
  // In-order responder: presents the oldest granted request once its latency expires.
  always @(posedge clk) begin
    #1;
    if (mem_q.size() > 0 && cyc >= mem_q[0].due) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      mem_q.delete();
      exp_q.delete();
      exp_req    = RESET_PC;
      prev_rst   = 1'b1;
      prev_redir = 1'b0;
      prev_hold  = 1'b0;
      prev_wait  = 1'b0;
    end else begin
      if (prev_rst) begin
        check(!imem_req,   "post_reset_req",   32'(imem_req),   32'h0);
        check(!inst_valid, "post_reset_valid", 32'(inst_valid), 32'h0);
      end
      if (!inst_valid) begin
        check(IR_out == 32'h0, "nop_ir", IR_out, 32'h0);
        check(PC_out == 32'h0, "nop_pc", PC_out, 32'h0);
      end
      if (prev_redir) begin
        check(!inst_valid, "flush_valid", 32'(inst_valid), 32'h0);
      end
`ifdef FETCH_ALIGN_CHECK_EN
      check(fetch_misalign == (prev_redir && (prev_rpc[1:0] != 2'b00)), "misalign_flag",
            32'(fetch_misalign), 32'(prev_redir && (prev_rpc[1:0] != 2'b00)));
`endif
      if (prev_hold) begin
        check(inst_valid,        "stall_hold_valid", 32'(inst_valid), 32'h1);
        check(PC_out == hold_pc, "stall_hold_pc",    PC_out, hold_pc);
        check(IR_out == hold_ir, "stall_hold_ir",    IR_out, hold_ir);
      end
      if (prev_wait) begin
        check(imem_req,               "req_hold",    32'(imem_req), 32'h1);
        check(imem_addr == wait_addr, "addr_stable", imem_addr, wait_addr);
      end

      // Instruction handed to IF/ID this cycle.
      if (inst_valid && !stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "phantom_inst", PC_out, 32'h0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check(PC_out == e + 32'd4,    "consume_pc", PC_out, e + 32'd4);
          check(IR_out == mem_word(e), "consume_ir", IR_out, mem_word(e));
          n_consumed++;
        end
      end

      // Request accepted this cycle.
      if (imem_req && imem_gnt) begin
        check(mem_q.size() < DEPTH, "credit_limit", 32'(mem_q.size()), 32'(DEPTH - 1));
        if (!redirect_valid) begin
          check(imem_addr == exp_req, "req_addr", imem_addr, exp_req);
          exp_q.push_back(exp_req);
          exp_req = exp_req + 32'd4;
        end
      end

      if (redirect_valid) begin
        exp_q.delete();
        exp_req = redirect_pc & 32'hFFFF_FFFC;
      end

      if (imem_rvalid && mem_q.size() > 0) begin
        void'(mem_q.pop_front());
      end
      if (imem_req && imem_gnt) begin
        mem_q.push_back('{addr: imem_addr, due: cyc + lat});
      end

      prev_rst   = 1'b0;
      prev_redir = redirect_valid;
      prev_rpc   = redirect_pc;
      prev_hold  = inst_valid && stall && !redirect_valid;
      hold_pc    = PC_out;
      hold_ir    = IR_out;
      prev_wait  = imem_req && !imem_gnt && !redirect_valid;
      wait_addr  = imem_addr;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, input string name);
    int n;
    n = 0;
    while (!inst_valid && n < max) begin
      step();
      n++;
    end
    check(inst_valid, name, 32'(inst_valid), 32'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst      = 1'b1;
    imem_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;

    // Reset-to-first-instruction: sequential addresses, 3-cycle latency.
    step();
    check(imem_req,                 "t1_req",      32'(imem_req), 32'h1);
    check(imem_addr == 32'h3000,    "t1_addr0",    imem_addr, 32'h3000);
    step();
    check(imem_addr == 32'h3004,    "t1_addr1",    imem_addr, 32'h3004);
    check(!inst_valid,              "t1_notyet",   32'(inst_valid), 32'h0);
    step();
    check(inst_valid,               "t1_valid",    32'(inst_valid), 32'h1);
    check(PC_out == 32'h3004,       "t1_pc",       PC_out, 32'h3004);
    check(IR_out == 32'h1357_9BEF,  "t1_ir",       IR_out, 32'h1357_9BEF);
    repeat (12) step();

    // Stall for 4 cycles: credits run out and the request drops.
    stall = 1'b1;
    repeat (3) step();
    check(!imem_req,  "t2_req_off", 32'(imem_req), 32'h0);
    check(inst_valid, "t2_valid",   32'(inst_valid), 32'h1);
    step();
    stall = 1'b0;
    repeat (8) step();

    // Redirect with two responses in flight.
    lat = 3;
    begin
      int n;
      n = 0;
      while (mem_q.size() != 2 && n < 40) begin
        step();
        n++;
      end
      check(mem_q.size() == 2, "t3_two_inflight", 32'(mem_q.size()), 32'h2);
    end
    do_redirect(32'h0000_4000);
    lat = 1;
    wait_valid(30, "t3_valid");
    check(PC_out == 32'h4004,      "t3_pc", PC_out, 32'h4004);
    check(IR_out == 32'h1357_9B9F, "t3_ir", IR_out, 32'h1357_9B9F);
    repeat (6) step();

    // PC wraps past the top of the address space.
    do_redirect(32'hFFFF_FFF8);
    wait_valid(20, "wrap_valid");
    check(PC_out == 32'hFFFF_FFFC, "wrap_pc", PC_out, 32'hFFFF_FFFC);
    repeat (8) step();

    // Misaligned redirect target is forced to a word boundary.
    do_redirect(32'h0000_5006);
`ifdef FETCH_ALIGN_CHECK_EN
    check(fetch_misalign, "mis_flag", 32'(fetch_misalign), 32'h1);
`endif
    begin
      int n;
      n = 0;
      while (!imem_req && n < 10) begin
        step();
        n++;
      end
      check(imem_req,               "mis_req",  32'(imem_req), 32'h1);
      check(imem_addr == 32'h5004, "mis_addr", imem_addr, 32'h5004);
    end
    repeat (6) step();

    // No grant for 5 cycles: request held, queue drains to NOP.
    begin
      int n;
      logic [31:0] a;
      n = 0;
      while (!imem_req && n < 10) begin
        step();
        n++;
      end
      imem_gnt = 1'b0;
      a = imem_addr;
      for (int k = 0; k < 5; k++) begin
        check(imem_req,       "t4_req",  32'(imem_req), 32'h1);
        check(imem_addr == a, "t4_addr", imem_addr, a);
        if (k < 4) step();
      end
      check(!inst_valid,     "t4_valid", 32'(inst_valid), 32'h0);
      check(IR_out == 32'h0, "t4_ir",    IR_out, 32'h0);
      imem_gnt = 1'b1;
      step();
    end
    repeat (6) step();

    // Reset while holding with a full queue.
    stall = 1'b1;
    begin
      int n;
      n = 0;
      while (!(!imem_req && inst_valid && mem_q.size() == 0) && n < 20) begin
        step();
        n++;
      end
      check(!imem_req && inst_valid, "t5_full_hold", 32'(imem_req), 32'h0);
    end
    rst = 1'b1;
    step();
    rst   = 1'b0;
    stall = 1'b0;
    check(!inst_valid, "t5_valid", 32'(inst_valid), 32'h0);
    check(!imem_req,   "t5_idle",  32'(imem_req),   32'h0);
    step();
    check(imem_req,                "t5_req",  32'(imem_req), 32'h1);
    check(imem_addr == RESET_PC,   "t5_addr", imem_addr, RESET_PC);
    repeat (20) step();

    check(n_consumed >= 10, "throughput", 32'(n_consumed), 32'd10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
